// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up and a start/busy/done handshake into HI/LO.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] portA,
    input  logic [WIDTH-1:0] portB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   count_reg;
    logic               is_div_reg;
    logic               neg_lo_reg;
    logic               neg_hi_reg;
    logic               dz_reg;
    logic [WIDTH-1:0]   operand_reg;
    logic [WIDTH-1:0]   work_reg;
    logic [WIDTH-1:0]   rem_reg;
    logic [WIDTH-1:0]   orig_a_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic               dz_out_reg;

    logic               signed_op;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_fits;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   work_step;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign signed_op = ~op[0];
    assign abs_a     = (signed_op && portA[WIDTH-1]) ? (~portA + 1'b1) : portA;
    assign abs_b     = (signed_op && portB[WIDTH-1]) ? (~portB + 1'b1) : portB;

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (count_reg == CNT_W'(WIDTH-1)) state_next = FIX;
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // rem_reg/work_reg are shared: {upper, lower} product halves when multiplying,
    // {partial remainder, dividend->quotient shift register} when dividing.
    always_comb begin
        mul_sum   = {1'b0, rem_reg} + (work_reg[0] ? {1'b0, operand_reg} : '0);
        div_shift = {rem_reg, work_reg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand_reg};
        div_fits  = ~div_diff[WIDTH];
        if (is_div_reg) begin
            rem_step  = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            work_step = {work_reg[WIDTH-2:0], div_fits};
        end else begin
            rem_step  = mul_sum[WIDTH:1];
            work_step = {mul_sum[0], work_reg[WIDTH-1:1]};
        end
    end

    always_comb begin
        product     = {rem_reg, work_reg};
        product_fix = neg_lo_reg ? (~product + 1'b1) : product;
        quo_fix     = neg_lo_reg ? (~work_reg + 1'b1) : work_reg;
        rem_fix     = neg_hi_reg ? (~rem_reg + 1'b1) : rem_reg;
        if (!is_div_reg) begin
            fix_hi = product_fix[2*WIDTH-1:WIDTH];
            fix_lo = product_fix[WIDTH-1:0];
        end else if (dz_reg) begin
            // Divide by zero reports the untouched dividend rather than the
            // all-ones quotient/magnitude the datapath naturally produces.
            fix_hi = orig_a_reg;
            fix_lo = '1;
        end else begin
            fix_hi = rem_fix;
            fix_lo = quo_fix;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            is_div_reg  <= 1'b0;
            neg_lo_reg  <= 1'b0;
            neg_hi_reg  <= 1'b0;
            dz_reg      <= 1'b0;
            operand_reg <= '0;
            work_reg    <= '0;
            rem_reg     <= '0;
            orig_a_reg  <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            dz_out_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        is_div_reg  <= op[1];
                        operand_reg <= op[1] ? abs_b : abs_a;
                        work_reg    <= op[1] ? abs_a : abs_b;
                        rem_reg     <= '0;
                        count_reg   <= '0;
                        neg_lo_reg  <= signed_op & (portA[WIDTH-1] ^ portB[WIDTH-1]);
                        neg_hi_reg  <= signed_op & op[1] & portA[WIDTH-1];
                        dz_reg      <= op[1] & (portB == '0);
                        orig_a_reg  <= portA;
                    end
                end
                RUN: begin
                    rem_reg   <= rem_step;
                    work_reg  <= work_step;
                    count_reg <= count_reg + 1'b1;
                end
                FIX: begin
                    hi_reg     <= fix_hi;
                    lo_reg     <= fix_lo;
                    dz_out_reg <= is_div_reg & dz_reg;
                end
                default: ;
            endcase
        end
    end

    assign hi          = hi_reg;
    assign lo          = lo_reg;
    assign div_by_zero = dz_out_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed MULT/DIV cases, handshake and
// reset-abort checks, plus random operations against a 64-bit arithmetic model.
module tb_mult_div_unit;

    logic        CLK;
    logic        nRST;
    logic        start;
    logic [1:0]  op;
    logic [31:0] portA;
    logic [31:0] portB;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        exp_q[$];
    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] prev_hi = '0;
    logic [31:0] prev_lo = '0;

    mult_div_unit #(.WIDTH(32)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .start       (start),
        .op          (op),
        .portA       (portA),
        .portB       (portB),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vec_cnt++;
        if (obs !== expv) begin
            err_cnt++;
            $display("FAIL %s: got %0h, required %0h", tag, obs, expv);
        end
    endtask

    function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] eh, output logic [31:0] el, output logic ed);
        longint      sa, sb;
        logic [63:0] p, q, r;
        sa = o[0] ? longint'({32'b0, a}) : longint'($signed(a));
        sb = o[0] ? longint'({32'b0, b}) : longint'($signed(b));
        ed = 1'b0;
        if (!o[1]) begin
            p  = 64'(sa * sb);
            eh = p[63:32];
            el = p[31:0];
        end else if (b == 32'd0) begin
            eh = a;
            el = 32'hFFFF_FFFF;
            ed = 1'b1;
        end else begin
            q  = 64'(sa / sb);
            r  = 64'(sa % sb);
            eh = r[31:0];
            el = q[31:0];
        end
    endfunction

    // Caller is #1 after an edge with the DUT in IDLE.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input logic ed, input bit inj);
        exp_t e;
        int   cyc;
        bit   seen;
        e.hi = eh;
        e.lo = el;
        e.dz = ed;
        exp_q.push_back(e);
        op    = o;
        portA = a;
        portB = b;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        portA = $urandom;
        portB = $urandom;
        op    = 2'($urandom_range(0, 3));
        cyc   = 1;
        seen  = 0;
        while (!seen && cyc <= 40) begin
            if (done) begin
                seen = 1;
            end else begin
                check("busy_run", 64'(busy), 64'd1);
                if (cyc == 10) begin
                    check("hold_hi", 64'(hi), 64'(prev_hi));
                    check("hold_lo", 64'(lo), 64'(prev_lo));
                end
                if (inj && cyc == 10) begin
                    start = 1'b1;
                    op    = 2'd1;
                    portA = 32'hDEAD_BEEF;
                    portB = 32'h0000_0011;
                end else begin
                    start = 1'b0;
                end
                @(posedge CLK); #1;
                cyc++;
            end
        end
        start = 1'b0;
        check("done_seen", 64'(seen), 64'd1);
        check("latency", 64'(cyc), 64'd34);
        check("busy_done", 64'(busy), 64'd0);
        e = exp_q.pop_front();
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("div_by_zero", 64'(div_by_zero), 64'(e.dz));
        $display("op=%0d a=%08h b=%08h -> hi=%08h lo=%08h dz=%0b cycles=%0d", o, a, b, hi, lo, div_by_zero, cyc);
        prev_hi = e.hi;
        prev_lo = e.lo;
        // start during the DONE cycle must not launch an operation
        start = 1'b1;
        op    = 2'd1;
        portA = 32'h0000_0005;
        portB = 32'h0000_0007;
        @(posedge CLK); #1;
        start = 1'b0;
        check("start_in_done_ignored", 64'(busy), 64'd0);
        check("done_one_cycle", 64'(done), 64'd0);
        check("hold_after_done", 64'({hi, lo}), {e.hi, e.lo});
    endtask

    initial begin
        logic [31:0] rh, rl, ra, rb;
        logic        rd;
        logic [1:0]  ro;
        nRST  = 1'b0;
        start = 1'b0;
        op    = 2'd0;
        portA = '0;
        portB = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_dz", 64'(div_by_zero), 64'd0);
        nRST = 1'b1;
        @(posedge CLK); #1;

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
        run_op(2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0);
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
        run_op(2'd3, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 0);
        run_op(2'd3, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 0);
        run_op(2'd1, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0, 1);
        run_op(2'd2, 32'd100,       32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2, 1'b0, 0);

        for (int i = 0; i < 8; i++) begin
            ro = 2'(i % 4);
            ra = $urandom;
            rb = (i >= 4) ? 32'($urandom_range(1, 1000)) : $urandom;
            ref_model(ro, ra, rb, rh, rl, rd);
            run_op(ro, ra, rb, rh, rl, rd, 0);
        end

        run_op(2'd2, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, 0);

        // Abort a DIV with reset at cycle 20 of its run
        op    = 2'd2;
        portA = 32'd1000;
        portB = 32'd7;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (19) @(posedge CLK);
        #1;
        check("abort_busy_before", 64'(busy), 64'd1);
        nRST = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        check("abort_dz", 64'(div_by_zero), 64'd0);
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        @(posedge CLK); #1;
        check("abort_idle", 64'(busy), 64'd0);
        prev_hi = '0;
        prev_lo = '0;
        run_op(2'd3, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
